nx_host_bridge: RTL
===================

NX_HOST_BRIDGE -- requirements
Module: nx_host_bridge

Interface
REQ-001 SHALL have parameter STREAM_WIDTH, default 32, width of a stream word.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, width of the mesh cycle counter and run length.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per buffer; must be a power of 2 and at least 2.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports host_wr_data_i in STREAM_WIDTH, host_wr_valid_i in 1, host_wr_ready_o out 1: host-to-mesh words.
REQ-007 SHALL have ports host_rd_data_o out STREAM_WIDTH, host_rd_valid_o out 1, host_rd_ready_i in 1: mesh-to-host words.
REQ-008 SHALL have ports mesh_in_data_o out STREAM_WIDTH, mesh_in_valid_o out 1, mesh_in_ready_i in 1: drives the mesh inbound stream.
REQ-009 SHALL have ports mesh_out_data_i in STREAM_WIDTH, mesh_out_valid_i in 1, mesh_out_ready_o out 1: sinks the mesh outbound stream.
REQ-010 SHALL have ports run_start_i in 1, run_stop_i in 1, run_cycles_i in COUNTER_WIDTH: run control.
REQ-011 SHALL have ports active_o out 1, counter_i in COUNTER_WIDTH, run_busy_o out 1: drive mesh active and observe the mesh cycle counter.

Function
REQ-012 SHALL transfer a word on any stream when valid and ready are both high at a rising edge.
REQ-013 SHALL hold a valid word's data stable and keep valid high until it is accepted.
REQ-014 SHALL buffer host-to-mesh words in egress FIFO E and mesh-to-host words in ingress FIFO I, each FIFO_DEPTH deep, preserving order.
REQ-015 SHALL drive host_wr_ready_o = !E.full and mesh_out_ready_o = !I.full; ready SHALL NOT depend on the same-cycle pop.
REQ-016 SHALL drive mesh_in_valid_o = !E.empty and host_rd_valid_o = !I.empty, with data taken from the FIFO head.
REQ-017 SHALL present a pushed word at the FIFO output one cycle after acceptance, with no combinational bypass.
REQ-018 SHALL perform push and pop together on a non-full, non-empty FIFO with no change in occupancy.
REQ-019 SHALL wrap FIFO pointers modulo FIFO_DEPTH and use an extra pointer bit to tell full from empty.
REQ-020 SHALL implement run FSM states IDLE and RUN.
REQ-021 SHALL go IDLE->RUN on run_start_i with run_cycles_i != 0, loading remaining = run_cycles_i and counter_q = counter_i.
REQ-022 SHALL ignore run_start_i when run_cycles_i == 0 or when already in RUN.
REQ-023 SHALL register counter_q <= counter_i every cycle, and in RUN SHALL decrement remaining by 1 each cycle that counter_i != counter_q.
REQ-024 SHALL drive active_o = (state==RUN) && (remaining != 0), combinationally.
REQ-025 SHALL go RUN->IDLE when remaining reaches 0, or on run_stop_i; run_stop_i wins over run_start_i when both are high.
REQ-026 SHALL drive run_busy_o = (state==RUN).
REQ-027 SHALL keep stream traffic independent of run state, flowing in IDLE and RUN alike.

Reset
REQ-028 SHALL, on rst_i, asynchronously empty both FIFOs, set state IDLE, remaining 0 and counter_q 0.
REQ-029 SHALL hold active_o, run_busy_o, mesh_in_valid_o and host_rd_valid_o at 0 during reset, with host_wr_ready_o and mesh_out_ready_o at 1.
REQ-030 SHALL discard buffered words and an in-progress run when reset is asserted mid-operation, with no partial transfer after release.

Structure
REQ-031 SHALL instantiate one sub-module nx_fifo twice, parameterised by WIDTH and DEPTH, with push/pop/full/empty/data ports.
REQ-032 SHALL place the run-state enum type nx_run_state_t in the shared package nx_pkg.
REQ-033 SHALL keep the implementation within 120-400 RTL lines, excluding nx_fifo.

Verification
REQ-034 SHALL cover: push 0x11,0x22,0x33 with mesh_in_ready_i=1 -> mesh_in_data_o shows 0x11,0x22,0x33 in order, first one cycle after push.
REQ-035 SHALL cover: FIFO_DEPTH=4 and mesh_in_ready_i=0, push 5 words -> host_wr_ready_o drops after the 4th; 5th accepted only after one pop.
REQ-036 SHALL cover: run_cycles_i=3 with counter_i stepping 10->11->12->13 -> active_o high until remaining=0, then run_busy_o=0; counter_i stalling holds RUN.
REQ-037 SHALL cover: run_start_i with run_cycles_i=0 -> stays IDLE, active_o=0; run_stop_i during RUN -> IDLE next cycle.
REQ-038 SHALL cover: host_rd_ready_i=0 while the mesh sends 6 words -> mesh_out_ready_o=0 after 4; on release host reads all 6 in order.
REQ-039 SHALL cover: rst_i pulsed mid-run with both FIFOs holding 2 words -> all valids 0, active_o 0 immediately; both FIFOs empty after release.

Source files
------------

// File: rtl/nx_pkg.sv
// Shared types and constants for the nx host bridge slice.
package nx_pkg;

    // Run controller state: IDLE waits for a start, RUN gates the mesh active signal.
    typedef enum logic [0:0] {
        RUN_IDLE = 1'b0,
        RUN_RUN  = 1'b1
    } nx_run_state_t;

    // Default geometry shared by the bridge and its buffers.
    localparam int NX_STREAM_WIDTH_DEF  = 32;
    localparam int NX_COUNTER_WIDTH_DEF = 32;
    localparam int NX_FIFO_DEPTH_DEF    = 4;

endpackage : nx_pkg

// File: rtl/nx_fifo.sv
// Synchronous FIFO with registered storage and head-of-queue output.
// DEPTH must be a power of two (>= 2); pointers carry one extra wrap bit
// so that full and empty are distinguished without an occupancy counter.
module nx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             push_en_s;
    logic             pop_en_s;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_en_s = push_i && !full_s;
    assign pop_en_s  = pop_i && !empty_s;

    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign pop_data_o = mem_r[rd_ptr_r[AW-1:0]];

    // Storage write: a pushed word becomes visible at the head on the next cycle only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_i;
        end
    end

    // Pointer update; natural binary wrap gives modulo-DEPTH indexing plus the wrap bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_en_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule : nx_fifo

// File: rtl/nx_host_bridge.sv
// Host <-> mesh stream bridge with a cycle-budgeted run controller.
// Stream traffic is buffered in two FIFOs and flows regardless of run state.
module nx_host_bridge
    import nx_pkg::*;
#(
    parameter int STREAM_WIDTH  = NX_STREAM_WIDTH_DEF,
    parameter int COUNTER_WIDTH = NX_COUNTER_WIDTH_DEF,
    parameter int FIFO_DEPTH    = NX_FIFO_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // host -> mesh
    input  logic [STREAM_WIDTH-1:0]  host_wr_data_i,
    input  logic                     host_wr_valid_i,
    output logic                     host_wr_ready_o,
    // mesh -> host
    output logic [STREAM_WIDTH-1:0]  host_rd_data_o,
    output logic                     host_rd_valid_o,
    input  logic                     host_rd_ready_i,
    // mesh inbound stream
    output logic [STREAM_WIDTH-1:0]  mesh_in_data_o,
    output logic                     mesh_in_valid_o,
    input  logic                     mesh_in_ready_i,
    // mesh outbound stream
    input  logic [STREAM_WIDTH-1:0]  mesh_out_data_i,
    input  logic                     mesh_out_valid_i,
    output logic                     mesh_out_ready_o,
    // run control
    input  logic                     run_start_i,
    input  logic                     run_stop_i,
    input  logic [COUNTER_WIDTH-1:0] run_cycles_i,
    output logic                     active_o,
    input  logic [COUNTER_WIDTH-1:0] counter_i,
    output logic                     run_busy_o
);

    logic e_full_s;
    logic e_empty_s;
    logic i_full_s;
    logic i_empty_s;

    nx_run_state_t            state_r;
    nx_run_state_t            state_nxt_s;
    logic [COUNTER_WIDTH-1:0] remaining_r;
    logic [COUNTER_WIDTH-1:0] remaining_nxt_s;
    logic [COUNTER_WIDTH-1:0] counter_q_r;
    logic                     counter_moved_s;
    logic                     remaining_zero_s;

    // Egress buffer: host writes, mesh inbound stream drains.
    nx_fifo #(
        .WIDTH (STREAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_egress (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (host_wr_valid_i),
        .push_data_i (host_wr_data_i),
        .pop_i       (mesh_in_ready_i),
        .pop_data_o  (mesh_in_data_o),
        .full_o      (e_full_s),
        .empty_o     (e_empty_s)
    );

    // Ingress buffer: mesh outbound stream fills, host reads drain.
    nx_fifo #(
        .WIDTH (STREAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_ingress (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (mesh_out_valid_i),
        .push_data_i (mesh_out_data_i),
        .pop_i       (host_rd_ready_i),
        .pop_data_o  (host_rd_data_o),
        .full_o      (i_full_s),
        .empty_o     (i_empty_s)
    );

    // Ready reflects only stored occupancy, never the same-cycle pop.
    assign host_wr_ready_o  = !e_full_s;
    assign mesh_out_ready_o = !i_full_s;
    assign mesh_in_valid_o  = !e_empty_s;
    assign host_rd_valid_o  = !i_empty_s;

    assign counter_moved_s  = (counter_i != counter_q_r);
    assign remaining_zero_s = (remaining_r == {COUNTER_WIDTH{1'b0}});

    assign run_busy_o = (state_r == RUN_RUN);
    assign active_o   = (state_r == RUN_RUN) && !remaining_zero_s;

    // Run controller registers; counter sample tracks the mesh counter every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= RUN_IDLE;
            remaining_r <= {COUNTER_WIDTH{1'b0}};
            counter_q_r <= {COUNTER_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            remaining_r <= remaining_nxt_s;
            counter_q_r <= counter_i;
        end
    end

    // Next-state: stop dominates start; RUN spends one unit per observed counter tick.
    always_comb begin
        state_nxt_s     = state_r;
        remaining_nxt_s = remaining_r;
        case (state_r)
            RUN_IDLE: begin
                if (!run_stop_i && run_start_i &&
                    (run_cycles_i != {COUNTER_WIDTH{1'b0}})) begin
                    state_nxt_s     = RUN_RUN;
                    remaining_nxt_s = run_cycles_i;
                end else begin
                    state_nxt_s     = RUN_IDLE;
                    remaining_nxt_s = remaining_r;
                end
            end
            RUN_RUN: begin
                if (run_stop_i) begin
                    state_nxt_s     = RUN_IDLE;
                    remaining_nxt_s = {COUNTER_WIDTH{1'b0}};
                end else if (remaining_zero_s) begin
                    state_nxt_s     = RUN_IDLE;
                    remaining_nxt_s = remaining_r;
                end else if (counter_moved_s) begin
                    state_nxt_s     = RUN_RUN;
                    remaining_nxt_s = remaining_r - {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s     = RUN_RUN;
                    remaining_nxt_s = remaining_r;
                end
            end
            default: begin
                state_nxt_s     = RUN_IDLE;
                remaining_nxt_s = {COUNTER_WIDTH{1'b0}};
            end
        endcase
    end

endmodule : nx_host_bridge
